// File: rtl/uart_tx_block.sv
// ---------------------------------------------------------------------------
// uart_tx_block
//   Asynchronous serial transmitter. Sends one frame for each accepted
//   tx_start strobe: a start bit, the data bits LSB-first, an optional
//   even-parity bit, and a stop bit. An internal bit-period counter sets
//   the bit timing. It uses the same rollover rule as the flexible counters
//   on the receive side.
//
// Parameters
//   NUM_DATA_BITS : data bits per frame (5..8)
//   CLKS_PER_BIT  : clock cycles per serial bit (>= 2)
//   PARITY_EN     : 1 inserts an even-parity bit after the data bits
//
// Ports
//   clk        in   rising-edge clock
//   n_rst      in   asynchronous active-low reset
//   tx_data    in   word to send, latched only when a start is accepted
//   tx_start   in   request strobe, level-sampled on every edge
//   serial_out out  registered serial line, idles high
//   tx_busy    out  high while a frame is in progress
//   tx_done    out  one-cycle pulse when the stop bit completes
// ---------------------------------------------------------------------------
module uart_tx_block #(
  parameter int NUM_DATA_BITS = 8,
  parameter int CLKS_PER_BIT  = 10,
  parameter int PARITY_EN     = 0
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [NUM_DATA_BITS-1:0] tx_data,
  input  logic                     tx_start,
  output logic                     serial_out,
  output logic                     tx_busy,
  output logic                     tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int IDX_W = $clog2(NUM_DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                   state, state_next;
  logic [CNT_W-1:0]         bit_cnt, bit_cnt_next;
  logic [IDX_W-1:0]         bit_idx, bit_idx_next;
  logic [NUM_DATA_BITS-1:0] shift_reg, shift_next;
  logic                     parity_bit, parity_next;
  logic                     serial_next, busy_next, done_next;

  logic                     rollover;
  logic [NUM_DATA_BITS-1:0] shifted;

  // The bit period ends on the cycle where the counter holds its top value.
  // The shifted copy gives the next data bit one edge early. serial_out is
  // registered, so the register has to load that bit on the same edge.
  assign rollover = (bit_cnt == CNT_MAX);
  assign shifted  = {1'b0, shift_reg[NUM_DATA_BITS-1:1]};

  // State and datapath registers. Reset forces the line high at once,
  // which aborts any frame in flight without a low glitch or a done pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      serial_out <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_next;
      bit_cnt    <= bit_cnt_next;
      bit_idx    <= bit_idx_next;
      shift_reg  <= shift_next;
      parity_bit <= parity_next;
      serial_out <= serial_next;
      tx_busy    <= busy_next;
      tx_done    <= done_next;
    end
  end

  // Next-state and next-output logic. The outputs are computed here as the
  // values they will hold after the coming edge. That is why the start bit
  // and tx_busy appear on the same edge that accepts tx_start.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift_reg;
    parity_next  = parity_bit;
    serial_next  = 1'b1;
    busy_next    = 1'b1;
    done_next    = 1'b0;

    case (state)
      IDLE: begin
        busy_next    = 1'b0;
        bit_cnt_next = '0;
        bit_idx_next = '0;
        if (tx_start) begin
          state_next   = START;
          shift_next   = tx_data;
          parity_next  = ^tx_data;
          bit_cnt_next = CNT_ONE;
          serial_next  = 1'b0;
          busy_next    = 1'b1;
        end
      end

      START: begin
        serial_next = 1'b0;
        if (rollover) begin
          state_next   = DATA;
          bit_cnt_next = CNT_ONE;
          bit_idx_next = '0;
          serial_next  = shift_reg[0];
        end else begin
          bit_cnt_next = bit_cnt + CNT_ONE;
        end
      end

      DATA: begin
        serial_next = shift_reg[0];
        if (rollover) begin
          bit_cnt_next = CNT_ONE;
          shift_next   = shifted;
          if (bit_idx == IDX_LAST) begin
            if (PARITY_EN != 0) begin
              state_next  = PARITY;
              serial_next = parity_bit;
            end else begin
              state_next  = STOP;
              serial_next = 1'b1;
            end
          end else begin
            bit_idx_next = bit_idx + IDX_W'(1);
            serial_next  = shifted[0];
          end
        end else begin
          bit_cnt_next = bit_cnt + CNT_ONE;
        end
      end

      PARITY: begin
        serial_next = parity_bit;
        if (rollover) begin
          state_next   = STOP;
          bit_cnt_next = CNT_ONE;
          serial_next  = 1'b1;
        end else begin
          bit_cnt_next = bit_cnt + CNT_ONE;
        end
      end

      STOP: begin
        serial_next = 1'b1;
        if (rollover) begin
          state_next   = IDLE;
          bit_cnt_next = '0;
          busy_next    = 1'b0;
          done_next    = 1'b1;
        end else begin
          bit_cnt_next = bit_cnt + CNT_ONE;
        end
      end

      default: begin
        state_next   = IDLE;
        bit_cnt_next = '0;
        busy_next    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_block.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_block
//   Directed bench for uart_tx_block. Two instances are used: the default
//   configuration, and a copy with even parity enabled. The expected serial
//   bits of each frame are queued when the frame is requested. They are
//   popped and compared at the middle of each bit period.
// ---------------------------------------------------------------------------
module tb_uart_tx_block;

  localparam int C = 10;

  logic       clk;
  logic       n_rst;
  logic [7:0] tx_data,  p_tx_data;
  logic       tx_start, p_tx_start;
  logic       serial_out, tx_busy, tx_done;
  logic       p_serial_out, p_tx_busy, p_tx_done;

  int n_checks;
  int n_fail;

  logic exp_q[$];

  uart_tx_block dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .serial_out (serial_out),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  uart_tx_block #(.PARITY_EN(1)) dut_par (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx_data    (p_tx_data),
    .tx_start   (p_tx_start),
    .serial_out (p_serial_out),
    .tx_busy    (p_tx_busy),
    .tx_done    (p_tx_done)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a frame never completes
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: observed timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: one immediate assertion per call
  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive the request lines of the selected instance
  task automatic driveStart(input bit par, input logic s, input logic [7:0] d);
    if (par) begin p_tx_start = s; p_tx_data = d; end
    else     begin tx_start   = s; tx_data   = d; end
  endtask

  // Queue the line levels that a frame of this data must produce
  task automatic pushFrame(input bit par, input logic [7:0] d);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (par) exp_q.push_back(^d);
    exp_q.push_back(1'b1);
  endtask

  // Request a frame. On return the accepting edge k has just occurred.
  task automatic applyStimulus(input bit par, input logic [7:0] d, input bit hold);
    @(negedge clk);
    driveStart(par, 1'b1, d);
    pushFrame(par, d);
    @(posedge clk);
    if (!hold) begin
      #1;
      if (par) p_tx_start = 1'b0; else tx_start = 1'b0;
    end
  endtask

  // Observe a frame at the negedge after edges k..k+F. Optionally pulse
  // tx_start with 0xFF at cycle intf_at, or change tx_data at cycle chg_at.
  task automatic watchFrame(input bit par, input string tag, input int intf_at,
                            input int chg_at, input logic [7:0] chg_data);
    int f, busy_cnt, done_cnt, stop_high;
    logic so, bz, dn, e;
    f = C * (par ? 11 : 10);
    busy_cnt = 0; done_cnt = 0; stop_high = 0;
    for (int j = 0; j <= f; j++) begin
      @(negedge clk);
      so = par ? p_serial_out : serial_out;
      bz = par ? p_tx_busy    : tx_busy;
      dn = par ? p_tx_done    : tx_done;
      if (bz) busy_cnt++;
      if (dn) done_cnt++;
      if (j == 0) begin
        checkOutput({tag, "_start_low"}, int'(so), 0);
        checkOutput({tag, "_busy_rise"}, int'(bz), 1);
      end
      if (j >= f - C && j < f && so) stop_high++;
      if (j < f && (j % C) == 5) begin
        if (exp_q.size() == 0) begin
          checkOutput({tag, "_queue_empty"}, 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput($sformatf("%s_bit%0d", tag, j / C), int'(so), int'(e));
        end
      end
      if (j == f) begin
        checkOutput({tag, "_end_busy"}, int'(bz), 0);
        checkOutput({tag, "_end_done"}, int'(dn), 1);
        checkOutput({tag, "_end_line"}, int'(so), 1);
      end
      if (j == intf_at)     driveStart(par, 1'b1, 8'hFF);
      if (j == intf_at + 1) driveStart(par, 1'b0, 8'hFF);
      if (j == chg_at) begin
        if (par) p_tx_data = chg_data; else tx_data = chg_data;
      end
    end
    checkOutput({tag, "_busy_cycles"}, busy_cnt, f);
    checkOutput({tag, "_done_pulses"}, done_cnt, 1);
    checkOutput({tag, "_stop_high"}, stop_high, C);
    checkOutput({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  // Directed sequence
  initial begin
    int done_seen;
    n_checks = 0;
    n_fail   = 0;
    n_rst      = 1'b0;
    tx_start   = 1'b1;
    tx_data    = 8'hA5;
    p_tx_start = 1'b0;
    p_tx_data  = 8'h00;

    // Reset held with tx_start high: the line stays idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_line", int'(serial_out), 1);
      checkOutput("rst_busy", int'(tx_busy), 0);
      checkOutput("rst_done", int'(tx_done), 0);
    end
    tx_start = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post_rst_busy", int'(tx_busy), 0);
    checkOutput("post_rst_line", int'(serial_out), 1);

    // Default frame 0xA5
    applyStimulus(1'b0, 8'hA5, 1'b0);
    watchFrame(1'b0, "a5", -10, -10, 8'h00);
    @(negedge clk);
    checkOutput("a5_done_clear", int'(tx_done), 0);

    // A start while busy is ignored
    applyStimulus(1'b0, 8'h3C, 1'b0);
    watchFrame(1'b0, "busy_ign", 40, -10, 8'h00);
    repeat (3) @(negedge clk);
    checkOutput("busy_ign_idle", int'(tx_busy), 0);

    // Back-to-back with tx_start held; data changes mid-frame
    applyStimulus(1'b0, 8'h01, 1'b1);
    watchFrame(1'b0, "b2b1", -10, 50, 8'h80);
    pushFrame(1'b0, 8'h80);
    @(posedge clk);
    #1 tx_start = 1'b0;
    watchFrame(1'b0, "b2b2", -10, -10, 8'h00);

    // Parity instance
    applyStimulus(1'b1, 8'h07, 1'b0);
    watchFrame(1'b1, "par07", -10, -10, 8'h00);
    applyStimulus(1'b1, 8'h03, 1'b0);
    watchFrame(1'b1, "par03", -10, -10, 8'h00);

    // Reset in the middle of a frame
    applyStimulus(1'b0, 8'h96, 1'b0);
    done_seen = 0;
    for (int j = 0; j < 37; j++) begin
      @(negedge clk);
      if (tx_done) done_seen++;
    end
    n_rst = 1'b0;
    #1;
    checkOutput("abort_line", int'(serial_out), 1);
    checkOutput("abort_busy", int'(tx_busy), 0);
    repeat (3) begin
      @(negedge clk);
      if (tx_done) done_seen++;
    end
    n_rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (tx_done) done_seen++;
    end
    checkOutput("abort_no_done", done_seen, 0);
    checkOutput("abort_idle_line", int'(serial_out), 1);
    exp_q.delete();

    // Recovery frame 0x55
    applyStimulus(1'b0, 8'h55, 1'b0);
    watchFrame(1'b0, "recov55", -10, -10, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
